// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment serial display driver: FSM state
// encoding, the hex-to-segment lookup table and the blank-digit pattern.
package seg_pkg;

  // Frame sequencer states. LOAD_PENDING is the reset state and always
  // starts a frame on the first clock after reset is released.
  typedef enum logic [2:0] {
    ST_WAIT         = 3'd0,
    ST_LOAD         = 3'd1,
    ST_SHIFT        = 3'd2,
    ST_LATCH        = 3'd3,
    ST_LOAD_PENDING = 3'd4
  } seg_state_e;

  // Number of serial bits per frame (8 digits x 8 segments).
  localparam int FRAME_BITS = 64;

  // Segment byte {dp,g,f,e,d,c,b,a}, active-low; all ones is a dark digit.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Hex digit glyphs, index = nibble value, decimal point off.
  localparam logic [7:0] HEX_SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Glyph lookup for one nibble.
  function automatic logic [7:0] hex_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// One display digit: hex nibble plus dot/enable flags to an active-low
// segment byte {dp,g,f,e,d,c,b,a}. Purely combinational.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dot_i,
  input  logic       en_i,
  output logic [7:0] seg_o
);

  // A disabled digit is fully dark, dot included; otherwise glyph plus
  // optional decimal point (bit 7, lit when low).
  always_comb begin
    seg_o = SEG_BLANK;
    if (en_i) begin
      seg_o = hex_seg(nibble_i);
      if (dot_i) begin
        seg_o[7] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_serial_driver.sv
// Serial driver for the 8-digit 7-segment display behind an external
// shift-register chain. Each frame snapshots data/dot/en, shifts 64
// active-low segment bits MSB-first on seg_clk/seg_do and then raises
// seg_pen to latch the chain. Frames repeat every REFRESH idle cycles or
// start early on an update request.
module seg_serial_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int REFRESH = 25000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] data,
  input  logic [7:0]  dot,
  input  logic [7:0]  en,
  input  logic        update,
  output logic        seg_clk,
  output logic        seg_do,
  output logic        seg_pen,
  output logic        seg_clr_n,
  output logic        busy,
  output logic        frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int REF_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH - 1);
  localparam logic [5:0]       BIT_LAST = 6'(FRAME_BITS - 1);

  seg_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;       // cycles spent in current half-bit / latch
  logic             phase_q, phase_d;   // 0: seg_clk low half, 1: high half
  logic [5:0]       bit_q, bit_d;       // bits already sent this frame
  logic [REF_W-1:0] ref_q, ref_d;       // idle cycles since the latch
  logic [63:0]      sr_q, sr_d;         // outgoing segment bits, MSB first
  logic             pending_q, pending_d;

  logic seg_clk_q, seg_clk_d;
  logic seg_do_q, seg_do_d;
  logic seg_pen_q, seg_pen_d;
  logic seg_clr_n_q;
  logic busy_q, busy_d;
  logic frame_done_q, frame_done_d;

  // Digit 7 lands in bits [63:56] so it is shifted out first.
  logic [63:0] snap;

  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    hex_to_seg u_dec (
      .nibble_i (data[gi*4 +: 4]),
      .dot_i    (dot[gi]),
      .en_i     (en[gi]),
      .seg_o    (snap[gi*8 +: 8])
    );
  end

  // Next-state logic: frame sequencing, bit-clock divider, bit counter,
  // refresh timer and the merged update request.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    ref_d        = ref_q;
    sr_d         = sr_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_LOAD_PENDING: begin
        state_d = ST_LOAD;
      end

      // The cycle entering WAIT is the latch cycle itself, so it already
      // counts as the first idle cycle of the refresh gap.
      ST_WAIT: begin
        if (pending_q || update || (ref_q == REF_LAST)) begin
          state_d = ST_LOAD;
          ref_d   = '0;
        end else begin
          ref_d = ref_q + 1'b1;
        end
      end

      // A request arriving while the snapshot is taken still earns a
      // follow-up frame, so it overrides the pending clear.
      ST_LOAD: begin
        sr_d      = snap;
        pending_d = update;
        div_d     = '0;
        phase_d   = 1'b0;
        bit_d     = '0;
        state_d   = ST_SHIFT;
      end

      // Shift happens together with the falling seg_clk so seg_do only
      // moves while seg_clk is low.
      ST_SHIFT: begin
        pending_d = pending_q | update;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            sr_d    = {sr_q[62:0], 1'b1};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = ST_LATCH;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_LATCH: begin
        pending_d = pending_q | update;
        if (div_q == DIV_LAST) begin
          div_d        = '0;
          ref_d        = '0;
          state_d      = ST_WAIT;
          frame_done_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_LOAD_PENDING;
      end
    endcase
  end

  // Pin values follow the upcoming state so every display pin comes
  // straight from a flop and never glitches.
  always_comb begin
    busy_d    = (state_d == ST_LOAD) || (state_d == ST_SHIFT) || (state_d == ST_LATCH);
    seg_pen_d = !busy_d;
    seg_clk_d = (state_d == ST_SHIFT) && phase_d;
    seg_do_d  = (state_d == ST_SHIFT) ? sr_d[63] : 1'b1;
  end

  // State and pin registers; reset aborts any frame in flight at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_LOAD_PENDING;
      div_q        <= '0;
      phase_q      <= 1'b0;
      bit_q        <= '0;
      ref_q        <= '0;
      sr_q         <= '1;
      pending_q    <= 1'b1;
      seg_clk_q    <= 1'b0;
      seg_do_q     <= 1'b1;
      seg_pen_q    <= 1'b1;
      seg_clr_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      ref_q        <= ref_d;
      sr_q         <= sr_d;
      pending_q    <= pending_d;
      seg_clk_q    <= seg_clk_d;
      seg_do_q     <= seg_do_d;
      seg_pen_q    <= seg_pen_d;
      seg_clr_n_q  <= 1'b1;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_clk    = seg_clk_q;
  assign seg_do     = seg_do_q;
  assign seg_pen    = seg_pen_q;
  assign seg_clr_n  = seg_clr_n_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Bench for seg_serial_driver: stimulus pushes the expected frame contents
// and inter-frame gaps into a scoreboard; a monitor reassembles the serial
// stream and checks each latched frame against it.
module tb_seg_serial_driver;

  localparam int CLK_DIV   = 2;
  localparam int REFRESH   = 10;
  localparam int FRAME_LEN = 1 + 128 * CLK_DIV + CLK_DIV;
  localparam int NFRAMES   = 14;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] data;
  logic [7:0]  dot;
  logic [7:0]  en;
  logic        update = 1'b0;
  logic        seg_clk, seg_do, seg_pen, seg_clr_n, busy, frame_done;

  always #5 clk = ~clk;

  seg_serial_driver #(.CLK_DIV(CLK_DIV), .REFRESH(REFRESH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .data       (data),
    .dot        (dot),
    .en         (en),
    .update     (update),
    .seg_clk    (seg_clk),
    .seg_do     (seg_do),
    .seg_pen    (seg_pen),
    .seg_clr_n  (seg_clr_n),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] word;
    int          gap;   // cycles frame_done -> next busy rise, -1 = unchecked
  } exp_t;
  exp_t sb[$];

  logic [7:0] hex_tbl [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Reference: digit i occupies byte i, blanked digits dark, dot clears bit 7.
  function automatic logic [63:0] model_frame(input logic [31:0] d, input logic [7:0] dp,
                                               input logic [7:0] e);
    logic [63:0] r;
    logic [7:0]  b;
    for (int i = 0; i < 8; i++) begin
      if (!e[i]) b = 8'hFF;
      else begin
        b = hex_tbl[d[i*4 +: 4]];
        if (dp[i]) b = b & 8'h7F;
      end
      r[i*8 +: 8] = b;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] w, input int g);
    exp_t e;
    e.word = w;
    e.gap  = g;
    sb.push_back(e);
  endtask

  task automatic wait_busy(input int limit);
    int n = 0;
    while (!busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!busy) begin
      checks++;
      failures++;
      $display("FAIL wait_busy: got no frame start after %0d cycles, expected busy=1", limit);
    end
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < limit);
    if (!frame_done) begin
      checks++;
      failures++;
      $display("FAIL wait_done: got no frame_done after %0d cycles, expected pulse", limit);
    end
  endtask

  task automatic pulse_update();
    #1 update = 1'b1;
    @(posedge clk);
    #1 update = 1'b0;
    @(posedge clk);
  endtask

  // Monitor: samples on the falling clk edge, rebuilds each frame from the
  // bits present at seg_clk rising edges and checks it at the seg_pen rise.
  int          cyc = 0;
  logic        clk_prev = 1'b0, pen_prev = 1'b1, busy_prev = 1'b0;
  logic [63:0] acc = '0;
  int          cap_n = 0, start_cyc = 0, fd_cyc = 0, gap_meas = -1, frame_no = 0;
  bit          have_fd = 1'b0;
  exp_t        mon_e;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      cap_n     = 0;
      have_fd   = 1'b0;
      gap_meas  = -1;
      clk_prev  = 1'b0;
      pen_prev  = 1'b1;
      busy_prev = 1'b0;
    end else begin
      if (seg_clk && !clk_prev) begin
        acc = {acc[62:0], seg_do};
        cap_n++;
      end
      if (busy && !busy_prev) begin
        start_cyc = cyc;
        gap_meas  = have_fd ? (cyc - fd_cyc) : -1;
      end
      if (frame_done) begin
        check("done_at_pen_rise", 64'({seg_pen, pen_prev}), 64'(2'b10));
        check("frame_len", 64'(cyc - start_cyc), 64'(FRAME_LEN));
        fd_cyc  = cyc;
        have_fd = 1'b1;
      end
      if (seg_pen && !pen_prev) begin
        check("bits_per_frame", 64'(cap_n), 64'(64));
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: got %h expected no frame", acc);
        end else begin
          mon_e = sb.pop_front();
          check("frame_word", acc, mon_e.word);
          if (mon_e.gap >= 0) check("frame_gap", 64'(gap_meas), 64'(mon_e.gap));
          $display("frame %0d word=%h exp=%h gap=%0d exp_gap=%0d",
                   frame_no, acc, mon_e.word, gap_meas, mon_e.gap);
        end
        frame_no++;
        cap_n = 0;
      end
      clk_prev  = seg_clk;
      pen_prev  = seg_pen;
      busy_prev = busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nd;
    logic [7:0]  ndot, nen;
    logic [63:0] w;
    int          gap, nupd, idle_d, mode;

    data = 32'h01234567;
    dot  = 8'h00;
    en   = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_seg_clk", 64'(seg_clk), 64'(0));
    check("rst_seg_do", 64'(seg_do), 64'(1));
    check("rst_seg_pen", 64'(seg_pen), 64'(1));
    check("rst_clr_n", 64'(seg_clr_n), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));

    push(64'hC0F9A4B0999282F8, -1);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("load_busy", 64'(busy), 64'(1));
    check("load_pen", 64'(seg_pen), 64'(0));
    check("load_clr_n", 64'(seg_clr_n), 64'(1));

    for (int k = 0; k < NFRAMES; k++) begin
      wait_busy(2 * (REFRESH + FRAME_LEN) + 10);

      if (k == NFRAMES - 1) begin
        // Abort a frame after bit 20 and require a clean full frame next.
        repeat (20 * 2 * CLK_DIV + 5) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("abort_seg_clk", 64'(seg_clk), 64'(0));
        check("abort_seg_do", 64'(seg_do), 64'(1));
        check("abort_seg_pen", 64'(seg_pen), 64'(1));
        check("abort_clr_n", 64'(seg_clr_n), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        sb.delete();
        push(model_frame(data, dot, en), -1);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        wait_busy(20);
        wait_done(FRAME_LEN + 20);
        break;
      end

      repeat ($urandom_range(10, 150)) @(posedge clk);
      nupd   = 0;
      idle_d = 0;
      nd     = data;
      ndot   = dot;
      nen    = en;
      case (k)
        0: begin
          nd = 32'h0; ndot = 8'h80; nen = 8'hFE;
          w = 64'h40C0C0C0C0C0C0FF;
          gap = REFRESH;
        end
        1: begin
          nd = $urandom; ndot = 8'h00; nen = 8'hFF;
          w = model_frame(nd, ndot, nen);
          nupd = 3;
          gap = 1;
        end
        2: begin
          w = model_frame(nd, ndot, nen);
          gap = REFRESH;
        end
        default: begin
          nd   = $urandom;
          ndot = 8'($urandom_range(0, 255));
          nen  = 8'($urandom_range(0, 255)) | 8'($urandom_range(0, 255));
          w    = model_frame(nd, ndot, nen);
          mode = $urandom_range(0, 3);
          case (mode)
            0: gap = REFRESH;
            1: begin nupd = $urandom_range(1, 3); gap = 1; end
            2: begin idle_d = $urandom_range(1, REFRESH - 3); gap = idle_d + 1; end
            default: begin idle_d = REFRESH - 1; gap = REFRESH; end
          endcase
        end
      endcase

      for (int u = 0; u < nupd; u++) pulse_update();
      #1;
      data = nd;
      dot  = ndot;
      en   = nen;
      push(w, gap);

      wait_done(FRAME_LEN + 20);
      if (idle_d > 0) begin
        repeat (idle_d) @(posedge clk);
        #1 update = 1'b1;
        @(posedge clk);
        #1 update = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_serial_driver.md
Name: seg_serial_driver

Overview:
- Serial driver for the board's 8-digit 7-segment display. It sits downstream of the debug/data mux and drives the SEGLED_CLK/SEGLED_DO/SEGLED_PEN pins through an external shift-register chain.
- Each frame snapshots a 32-bit hex word plus per-digit dot and enable masks. It converts them to 64 active-low segment bits, shifts the bits out MSB-first, and pulses the latch.
- Frames repeat on a refresh timer, or start immediately on an update request.

Parameters:
- CLK_DIV, default 2: seg_clk half-period in clk cycles (must be ≥1). One bit takes 2*CLK_DIV cycles.
- REFRESH, default 25000: idle clk cycles between frames (1 ms at 25 MHz). Must be ≥1.

Ports:
- clk  input  1  system clock (display domain, 25 MHz).
- rstn  input  1  asynchronous active-low reset.
- data  input  32  hex value; nibble i drives digit i, digit 7 leftmost.
- dot  input  8  dot[i]=1 lights the decimal point of digit i.
- en  input  8  en[i]=0 blanks digit i, including its dot.
- update  input  1  single-cycle request to start a frame as soon as possible.
- seg_clk  output  1  serial shift clock to the display chain.
- seg_do  output  1  serial data; changes only while seg_clk is low.
- seg_pen  output  1  latch/enable. Low while shifting; its rising edge latches the chain.
- seg_clr_n  output  1  chain clear. Low in reset, high afterwards.
- busy  output  1  high from LOAD through LATCH.
- frame_done  output  1  one-cycle pulse when the latch completes.

Behaviour:
- Reset (rstn=0, async): state=LOAD_PENDING. Outputs: seg_clk=0, seg_do=1, seg_pen=1, seg_clr_n=0, busy=0, frame_done=0. All counters are 0 and the pending flag is 1.
- The first frame starts on the first clk after reset deasserts.
- States and transitions:
  - WAIT: refresh counter counts to REFRESH-1. Leave to LOAD when the count expires, or on update/pending, whichever comes first.
  - LOAD (1 cycle):
    - Snapshot data/dot/en into a 64-bit shift register and clear pending.
    - Bits [63:56] hold digit 7, down to bits [7:0] for digit 0.
    - Set busy=1, seg_pen=0.
  - SHIFT: 64 bits, each 2*CLK_DIV cycles.
    - seg_do = sr[63] presented with seg_clk=0 for CLK_DIV cycles, then seg_clk=1 for CLK_DIV cycles. The rising edge falls mid-bit.
    - Shift left on each seg_clk falling edge; a 6-bit counter tracks bits sent.
  - LATCH: seg_clk=0, seg_do=1, seg_pen held low for CLK_DIV cycles, then driven to 1.
    - frame_done pulses in the cycle seg_pen rises.
    - Go to LOAD if pending, otherwise WAIT (busy=0, refresh counter cleared).
- Segment byte format is {dp,g,f,e,d,c,b,a}, active-low (0 = lit).
  - Hex decode: 0→C0 1→F9 2→A4 3→B0 4→99 5→92 6→82 7→F8 8→80 9→90 A→88 b→83 C→C6 d→A1 E→86 F→8E.
  - dot[i]=1 clears bit 7.
  - en[i]=0 forces the byte to FF.
- Timing: LOAD→first rising seg_clk takes CLK_DIV+1 cycles. A full frame is 1 + 128*CLK_DIV + CLK_DIV cycles.
- Input changes during a frame are ignored (snapshot only).
- Update while busy sets pending. Pending is a single flag, so multiple requests merge into exactly one follow-up frame, started right after LATCH with no WAIT.
- Update in the same cycle as refresh expiry starts one frame only.
- Reset mid-frame aborts immediately to reset values. A fresh full frame follows; a partial chain is never latched.

Decomposition:
- Shared package `seg_pkg`:
  - state encoding (WAIT, LOAD, SHIFT, LATCH, LOAD_PENDING);
  - the 16-entry hex→segment constant table;
  - SEG_BLANK=8'hFF.
- One combinational sub-module `hex_to_seg` (nibble, dot, en → byte), instantiated 8×.
- The FSM, divider, bit counter and refresh timer live in the top of this block.

Test Plan:
1. Reset: hold rstn=0 → seg_clk=0, seg_do=1, seg_pen=1, seg_clr_n=0, busy=0. Release → LOAD on the next clk, busy=1, seg_pen=0.
2. Serial content: data=32'h01234567, dot=0, en=FF, CLK_DIV=2 → bits sampled on seg_clk rising edges equal C0 F9 A4 B0 99 92 82 F8, MSB-first. frame_done fires exactly 1+256+2 cycles after LOAD.
3. Dot/blank: data=0, dot=8'h80, en=8'hFE → captured bytes are 40 C0 C0 C0 C0 C0 C0 FF.
4. Update during a frame: pulse update 3× mid-SHIFT and change data → the current frame shows the old data. Exactly one extra frame with the new data starts the cycle after frame_done, with no REFRESH gap.
5. Refresh: REFRESH=10, no update → consecutive frame_done pulses are exactly 1+128*CLK_DIV+CLK_DIV+10 cycles apart.
6. Reset mid-SHIFT (after bit 20) → outputs return to reset values asynchronously, and no seg_pen rising edge occurs before a complete new 64-bit frame.
